// File: rtl/pwm_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank_if
// Brief    : Byte-wide register write port for the PWM bank.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_bank_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank
// Brief    : Multi-channel PWM generator with prescaler, run bit and
//            double-buffered duty registers applied at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_bank #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  pwm_bank_if.slave         bus,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam logic [ADDR_W-1:0] c_ADDR_OUT_EN   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_ADDR_MODE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_PRESCALE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_ADDR_CTRL     = ADDR_W'(3);
  localparam int                c_DUTY_BASE     = 16;
  localparam logic [DATA_W-1:0] c_CNT_MAX       = {{(DATA_W-1){1'b1}}, 1'b0};
  localparam logic [DATA_W-1:0] c_DUTY_FULL     = {DATA_W{1'b1}};

  logic [NUM_CH-1:0] out_en_q;
  logic [NUM_CH-1:0] mode_q;
  logic [7:0]        presc_q;
  logic              run_q;
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] act_q    [NUM_CH];

  logic [7:0]        pre_q, pre_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              started_q, started_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              pstart_q, pstart_d;
  logic              w_tick;
  logic              w_wrap;

  // Register file: control registers and per-channel shadow duties
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q <= '0;
      mode_q   <= '0;
      presc_q  <= '0;
      run_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        c_ADDR_OUT_EN:   out_en_q <= bus.wr_data[NUM_CH-1:0];
        c_ADDR_MODE:     mode_q   <= bus.wr_data[NUM_CH-1:0];
        c_ADDR_PRESCALE: presc_q  <= 8'(bus.wr_data);
        c_ADDR_CTRL:     run_q    <= bus.wr_data[0];
        default:         ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.wr_addr == ADDR_W'(c_DUTY_BASE + i)) begin
          shadow_q[i] <= bus.wr_data;
        end
      end
    end
  end

  always_comb begin
    w_tick    = run_q && (pre_q == presc_q);
    w_wrap    = w_tick && (cnt_q == c_CNT_MAX);
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    pwm_d     = '0;
    if (!run_q) begin
      pre_d     = '0;
      cnt_d     = '0;
      started_d = 1'b0;
    end else if (w_tick) begin
      pre_d     = '0;
      cnt_d     = w_wrap ? '0 : cnt_q + DATA_W'(1);
      started_d = 1'b1;
    end else begin
      // pre wraps through 255 when D was lowered below the current count
      pre_d = pre_q + 8'd1;
    end
    // The first tick after RUN rises also marks a period start
    pstart_d = w_wrap || (w_tick && !started_q);
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = out_en_q[i] &
                 (mode_q[i] ? (run_q & ((act_q[i] == c_DUTY_FULL) | (cnt_q < act_q[i])))
                            : 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      pwm_q     <= '0;
      pstart_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_q[i] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      pwm_q     <= pwm_d;
      pstart_q  <= pstart_d;
      // Shadows load at the wrap, and continuously while stopped
      if (!run_q || w_wrap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          act_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_bank
// Brief    : Directed self-checking bench for pwm_bank (8 ch, 8-bit duty).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_bank;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] A_OUT_EN = 5'h00;
  localparam logic [ADDR_W-1:0] A_MODE   = 5'h01;
  localparam logic [ADDR_W-1:0] A_PRESC  = 5'h02;
  localparam logic [ADDR_W-1:0] A_CTRL   = 5'h03;
  localparam logic [ADDR_W-1:0] A_DUTY0  = 5'h10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;
  int                checks = 0;
  int                errors = 0;

  pwm_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pwm_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic drive_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  // Returns on the negedge after the edge that captured the write
  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk); drive_wr(a, d);
    @(negedge clk); drive_idle();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pstart(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (period_start) begin found = 1'b1; return; end
    end
  endtask

  task automatic program_ch0(input logic [7:0] duty, input logic [7:0] presc);
    write_reg(A_CTRL, 8'h00);
    write_reg(A_OUT_EN, 8'h01);
    write_reg(A_MODE, 8'h01);
    write_reg(A_PRESC, presc);
    write_reg(A_DUTY0, duty);
    write_reg(A_CTRL, 8'h01);
  endtask

  task automatic test_reset();
    int bad_out, bad_ps;
    drive_idle(); rst = 1'b1;
    @(negedge clk); drive_wr(A_OUT_EN, 8'($urandom_range(0, 255)) | 8'h81);
    @(negedge clk);
    checks++;
    if (pwm_out !== 8'h00 || period_start !== 1'b0) begin
      errors++; $display("FAIL reset_first_edge: pwm_out=%h ps=%b, expected 00/0", pwm_out, period_start);
    end
    drive_wr(A_CTRL, 8'($urandom_range(0, 255)) | 8'h01);
    @(negedge clk); rst = 1'b0; drive_idle();
    bad_out = 0; bad_ps = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm_out !== 8'h00) bad_out++;
      if (period_start !== 1'b0) bad_ps++;
    end
    checks++;
    if (bad_out != 0 || bad_ps != 0) begin
      errors++; $display("FAIL reset_no_reg_change: nonzero out %0d ps %0d cycles, expected 0/0", bad_out, bad_ps);
    end
    // Unmapped addresses must not alias onto OUT_EN or CTRL
    write_reg(5'h04, 8'hFF); write_reg(5'h07, 8'hFF); write_reg(5'h0F, 8'hFF);
    write_reg(5'h18, 8'hFF); write_reg(5'h1F, 8'hFF);
    bad_out = 0; bad_ps = 0;
    repeat (20) begin
      @(negedge clk);
      if (pwm_out !== 8'h00) bad_out++;
      if (period_start !== 1'b0) bad_ps++;
    end
    checks++;
    if (bad_out != 0 || bad_ps != 0) begin
      errors++; $display("FAIL unmapped_write: nonzero out %0d ps %0d cycles, expected 0/0", bad_out, bad_ps);
    end
    // OUT_EN with MODE=0 is static high, one cycle after the write
    write_reg(A_OUT_EN, 8'h05);
    checks++;
    if (pwm_out !== 8'h00) begin
      errors++; $display("FAIL out_en_latency0: pwm_out=%h expected 00", pwm_out);
    end
    @(negedge clk);
    checks++;
    if (pwm_out !== 8'h05) begin
      errors++; $display("FAIL out_en_latency1: pwm_out=%h expected 05", pwm_out);
    end
  endtask

  task automatic test_basic_pwm();
    bit found;
    int hi, ps, ps_pos, oth;
    logic at128, at129;
    do_reset();
    program_ch0(8'h80, 8'h00);
    repeat (20) @(negedge clk);
    wait_pstart(600, found);
    checks++;
    if (!found) begin errors++; $display("FAIL basic_pstart_timeout: no period_start within 600 cycles"); end
    for (int w = 0; w < 2; w++) begin
      hi = 0; ps = 0; ps_pos = 0; oth = 0; at128 = 1'b0; at129 = 1'b1;
      for (int j = 1; j <= 255; j++) begin
        @(negedge clk);
        if (pwm_out[0]) hi++;
        if (period_start) begin ps++; ps_pos = j; end
        if (pwm_out[7:1] != 7'd0) oth++;
        if (j == 128) at128 = pwm_out[0];
        if (j == 129) at129 = pwm_out[0];
      end
      checks++;
      if (hi != 128) begin errors++; $display("FAIL basic_high_count: got %0d expected 128", hi); end
      checks++;
      if (ps != 1 || ps_pos != 255) begin
        errors++; $display("FAIL basic_period: %0d pulses at %0d, expected 1 at 255", ps, ps_pos);
      end
      checks++;
      if (at128 !== 1'b1 || at129 !== 1'b0 || oth != 0) begin
        errors++; $display("FAIL basic_phase: s128=%b s129=%b other=%0d, expected 1 0 0", at128, at129, oth);
      end
    end
  endtask

  task automatic test_duty_extremes();
    int hi;
    logic s0, s1;
    write_reg(A_CTRL, 8'h00); write_reg(A_DUTY0, 8'h00); write_reg(A_CTRL, 8'h01);
    hi = 0;
    repeat (300) begin @(negedge clk); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL duty_zero: high %0d expected 0", hi); end
    write_reg(A_CTRL, 8'h00); write_reg(A_DUTY0, 8'hFF); write_reg(A_CTRL, 8'h01);
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (765) begin @(negedge clk); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != 765) begin errors++; $display("FAIL duty_full: high %0d expected 765", hi); end
    // RUN 1->0: PWM output drops one cycle after the write edge
    drive_wr(A_CTRL, 8'h00);
    @(negedge clk); drive_idle(); s0 = pwm_out[0];
    @(negedge clk); s1 = pwm_out[0];
    checks++;
    if (s0 !== 1'b1 || s1 !== 1'b0) begin
      errors++; $display("FAIL run_stop_latency: got %b%b expected 10", s0, s1);
    end
    write_reg(A_MODE, 8'h00);
    @(negedge clk);
    checks++;
    if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL static_stopped: got %b expected 1", pwm_out[0]); end
    write_reg(A_DUTY0, 8'h00); write_reg(A_CTRL, 8'h01);
    hi = 0;
    repeat (300) begin @(negedge clk); if (pwm_out[0]) hi++; end
    checks++;
    if (hi != 300) begin errors++; $display("FAIL static_running: high %0d expected 300", hi); end
  endtask

  task automatic test_double_buffer();
    bit found;
    int hi [4];
    int ps [4];
    int exp_hi [4] = '{64, 192, 192, 64};
    program_ch0(8'h40, 8'h00);
    repeat (5) @(negedge clk);
    wait_pstart(600, found);
    checks++;
    if (!found) begin errors++; $display("FAIL dbuf_pstart_timeout: no period_start within 600 cycles"); end
    for (int w = 0; w < 4; w++) begin
      hi[w] = 0; ps[w] = 0;
      for (int j = 1; j <= 255; j++) begin
        @(negedge clk);
        if (pwm_out[0]) hi[w]++;
        if (period_start && j == 255) ps[w]++;
        else if (period_start) ps[w] += 100;
        if (w == 0 && j == 100) drive_wr(A_DUTY0, 8'hC0);
        else if (w == 1 && j == 254) drive_wr(A_DUTY0, 8'h40);
        else drive_idle();
      end
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (hi[w] != exp_hi[w]) begin
        errors++; $display("FAIL dbuf_period%0d_high: got %0d expected %0d", w, hi[w], exp_hi[w]);
      end
      checks++;
      if (ps[w] != 1) begin
        errors++; $display("FAIL dbuf_period%0d_pstart: score %0d expected 1", w, ps[w]);
      end
    end
  endtask

  task automatic test_prescaler();
    bit found;
    int hi, ps, ps_pos;
    program_ch0(8'h10, 8'h03);
    repeat (10) @(negedge clk);
    wait_pstart(2500, found);
    checks++;
    if (!found) begin errors++; $display("FAIL presc_pstart_timeout: no period_start within 2500 cycles"); end
    hi = 0; ps = 0; ps_pos = 0;
    for (int j = 1; j <= 1020; j++) begin
      @(negedge clk);
      if (pwm_out[0]) hi++;
      if (period_start) begin ps++; ps_pos = j; end
    end
    checks++;
    if (hi != 64 || ps != 1 || ps_pos != 1020) begin
      errors++; $display("FAIL presc_d3: high %0d pulses %0d at %0d, expected 64 1 1020", hi, ps, ps_pos);
    end
    // D lowered to 0 while pre=1: pre runs to 255 and wraps before the next tick
    hi = 0; ps = 0; ps_pos = 0;
    for (int j = 1; j <= 571; j++) begin
      @(negedge clk);
      if (pwm_out[0]) hi++;
      if (period_start) begin ps++; ps_pos = j; end
      if (j == 81) drive_wr(A_PRESC, 8'h00); else drive_idle();
    end
    checks++;
    if (hi != 64 || ps != 1 || ps_pos != 571) begin
      errors++; $display("FAIL presc_change: high %0d pulses %0d at %0d, expected 64 1 571", hi, ps, ps_pos);
    end
    hi = 0; ps = 0; ps_pos = 0;
    for (int j = 1; j <= 255; j++) begin
      @(negedge clk);
      if (pwm_out[0]) hi++;
      if (period_start) begin ps++; ps_pos = j; end
    end
    checks++;
    if (hi != 16 || ps != 1 || ps_pos != 255) begin
      errors++; $display("FAIL presc_d0: high %0d pulses %0d at %0d, expected 16 1 255", hi, ps, ps_pos);
    end
  endtask

  task automatic test_multi_channel();
    bit found;
    int hi [NUM_CH];
    int bad_out, bad_ps;
    logic [NUM_CH-1:0] s100;
    do_reset();
    write_reg(A_OUT_EN, 8'hFF); write_reg(A_MODE, 8'hFF); write_reg(A_PRESC, 8'h00);
    for (int i = 0; i < NUM_CH; i++) write_reg(ADDR_W'(16 + i), DATA_W'(i * 32));
    write_reg(A_CTRL, 8'h01);
    repeat (5) @(negedge clk);
    wait_pstart(600, found);
    checks++;
    if (!found) begin errors++; $display("FAIL multi_pstart_timeout: no period_start within 600 cycles"); end
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    for (int j = 1; j <= 255; j++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) hi[i]++;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (hi[i] != i * 32) begin
        errors++; $display("FAIL multi_ch%0d_high: got %0d expected %0d", i, hi[i], i * 32);
      end
    end
    repeat (100) @(negedge clk);
    s100 = pwm_out;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s100 !== 8'hF0) begin errors++; $display("FAIL multi_cycle100: pwm_out=%h expected f0", s100); end
    checks++;
    if (pwm_out !== 8'h00 || period_start !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: pwm_out=%h ps=%b expected 00/0", pwm_out, period_start);
    end
    @(negedge clk); rst = 1'b0;
    bad_out = 0; bad_ps = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_out !== 8'h00) bad_out++;
      if (period_start !== 1'b0) bad_ps++;
    end
    checks++;
    if (bad_out != 0 || bad_ps != 0) begin
      errors++; $display("FAIL no_resume: nonzero out %0d ps %0d cycles, expected 0/0", bad_out, bad_ps);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic_pwm();
    test_duty_extremes();
    test_double_buffer();
    test_prescaler();
    test_multi_channel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
